// File: rtl/radix_4_ntt_pe_pipe_if.sv
// Beat-level handshake bundle for the radix-4 NTT butterfly PE.
// Input beat (x, tf, inv) and output beat (y, out_inv), each with valid/ready.
interface radix_4_ntt_pe_pipe_if #(
  parameter int unsigned N = 5
) ();
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [N-1:0] x0, x1, x2, x3;
  logic [N-1:0] tf1, tf2, tf3;
  logic         out_valid;
  logic         out_ready;
  logic         out_inv;
  logic [N-1:0] y0, y1, y2, y3;

  modport master (
    output in_valid, inv, x0, x1, x2, x3, tf1, tf2, tf3, out_ready,
    input  in_ready, out_valid, out_inv, y0, y1, y2, y3
  );

  modport slave (
    input  in_valid, inv, x0, x1, x2, x3, tf1, tf2, tf3, out_ready,
    output in_ready, out_valid, out_inv, y0, y1, y2, y3
  );
endinterface

// File: rtl/radix_4_ntt_pe_pipe.sv
// Elastic radix-4 NTT/INTT butterfly PE: operand capture, products, sums, outputs.
// RADIX4_NTT_PE_SCALE_EN adds a stage scaling inverse beats by 4^-1 mod Q.
module radix_4_ntt_pe_pipe #(
  parameter int unsigned N  = 5,
  parameter int unsigned Q  = 17,
  parameter int unsigned W4 = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  radix_4_ntt_pe_pipe_if.slave bus
);
  localparam int unsigned   PW = 2 * N;
  localparam logic [N:0]    QE = (N + 1)'(Q);
  localparam logic [PW-1:0] QW = PW'(Q);
  localparam logic [N-1:0]  RF = N'(W4);
  localparam logic [N-1:0]  RI = N'(Q - W4);

  function automatic logic [N-1:0] mod_red(input logic [PW-1:0] v);
    return N'(v % QW);
  endfunction

  function automatic logic [PW-1:0] mul_full(input logic [N-1:0] a, input logic [N-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  function automatic logic [N-1:0] add_mod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QE) s = s - QE;
    return N'(s);
  endfunction

  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + QE - {1'b0, b});
    return N'(s);
  endfunction

  // Capture stage: raw operands.
  logic                  c_valid_q, c_inv_q;
  logic [3:0][N-1:0]     c_x_q;
  logic [2:0][N-1:0]     c_tf_q;
  // S1: full-width products.
  logic                  s1_valid_q, s1_inv_q;
  logic [N-1:0]          s1_x0_q;
  logic [2:0][PW-1:0]    s1_p_q, s1_p_d;
  // S2: reduced sums and the pre-rotation difference.
  logic                  s2_valid_q, s2_inv_q;
  logic [N-1:0]          s2_t0_q, s2_t1_q, s2_t2_q, s2_d_q;
  logic [N-1:0]          s2_t0_d, s2_t1_d, s2_t2_d, s2_d_d;
  // S3: butterfly outputs.
  logic                  s3_valid_q, s3_inv_q;
  logic [3:0][N-1:0]     s3_y_q, s3_y_d;
  logic [N-1:0]          r1, r2, r3, t3;
  logic                  c_rdy, s1_rdy, s2_rdy, s3_rdy;

`ifdef RADIX4_NTT_PE_SCALE_EN
  logic                  s4_valid_q, s4_inv_q, s4_rdy;
  logic [3:0][N-1:0]     s4_y_q, s4_y_d;

  function automatic logic [N-1:0] half_mod(input logic [N-1:0] a);
    logic [N:0] s;
    s = a[0] ? ({1'b0, a} + QE) : {1'b0, a};
    return N'(s >> 1);
  endfunction

  assign s4_rdy = !s4_valid_q || bus.out_ready;
  assign s3_rdy = !s3_valid_q || s4_rdy;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s4_y_d[i] = s3_inv_q ? half_mod(half_mod(s3_y_q[i])) : s3_y_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_valid_q <= 1'b0;
      s4_inv_q   <= 1'b0;
      s4_y_q     <= '0;
    end else if (s4_rdy) begin
      s4_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        s4_inv_q <= s3_inv_q;
        s4_y_q   <= s4_y_d;
      end
    end
  end

  assign bus.out_valid = s4_valid_q;
  assign bus.out_inv   = s4_inv_q;
  assign {bus.y3, bus.y2, bus.y1, bus.y0} = s4_y_q;
`else
  assign s3_rdy = !s3_valid_q || bus.out_ready;

  assign bus.out_valid = s3_valid_q;
  assign bus.out_inv   = s3_inv_q;
  assign {bus.y3, bus.y2, bus.y1, bus.y0} = s3_y_q;
`endif

  // Ready ripples back combinationally so a full pipe keeps streaming.
  assign s2_rdy       = !s2_valid_q || s3_rdy;
  assign s1_rdy       = !s1_valid_q || s2_rdy;
  assign c_rdy        = !c_valid_q || s1_rdy;
  assign bus.in_ready = c_rdy;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s1_p_d[i] = mul_full(c_x_q[i+1], c_tf_q[i]);
    end
    r1      = mod_red(s1_p_q[0]);
    r2      = mod_red(s1_p_q[1]);
    r3      = mod_red(s1_p_q[2]);
    s2_t0_d = add_mod(s1_x0_q, r2);
    s2_t1_d = sub_mod(s1_x0_q, r2);
    s2_t2_d = add_mod(r1, r3);
    s2_d_d  = sub_mod(r1, r3);
    t3        = mod_red(mul_full(s2_d_q, s2_inv_q ? RI : RF));
    s3_y_d[0] = add_mod(s2_t0_q, s2_t2_q);
    s3_y_d[1] = add_mod(s2_t1_q, t3);
    s3_y_d[2] = sub_mod(s2_t0_q, s2_t2_q);
    s3_y_d[3] = sub_mod(s2_t1_q, t3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q  <= 1'b0;
      c_inv_q    <= 1'b0;
      c_x_q      <= '0;
      c_tf_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_x0_q    <= '0;
      s1_p_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_t0_q    <= '0;
      s2_t1_q    <= '0;
      s2_t2_q    <= '0;
      s2_d_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_inv_q   <= 1'b0;
      s3_y_q     <= '0;
    end else begin
      if (c_rdy) begin
        c_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          c_inv_q <= bus.inv;
          c_x_q   <= {bus.x3, bus.x2, bus.x1, bus.x0};
          c_tf_q  <= {bus.tf3, bus.tf2, bus.tf1};
        end
      end
      if (s1_rdy) begin
        s1_valid_q <= c_valid_q;
        if (c_valid_q) begin
          s1_inv_q <= c_inv_q;
          s1_x0_q  <= c_x_q[0];
          s1_p_q   <= s1_p_d;
        end
      end
      if (s2_rdy) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_inv_q <= s1_inv_q;
          s2_t0_q  <= s2_t0_d;
          s2_t1_q  <= s2_t1_d;
          s2_t2_q  <= s2_t2_d;
          s2_d_q   <= s2_d_d;
        end
      end
      if (s3_rdy) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_inv_q <= s2_inv_q;
          s3_y_q   <= s3_y_d;
        end
      end
    end
  end
endmodule

// File: doc/radix_4_ntt_pe_pipe.md
Name: radix_4_ntt_pe_pipe

Overview:
- Pipelined, elastic radix-4 butterfly processing element for the NTT/INTT datapath.
- Computes forward or inverse radix-4 butterflies selectable per beat.
- Parametrised in coefficient width and modulus.
- Uses a valid/ready handshake at both ends, so it can sit between the coefficient memory reader and the write-back stage with back-pressure.

Parameters:
- N, 5: coefficient width in bits.
- Q, 17: prime modulus; Q < 2^N.
- W4, 4: primitive 4th root of unity mod Q (W4*W4 mod Q = Q-1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  PE can accept a beat this cycle
- inv  input  1  0 = forward NTT butterfly, 1 = inverse (INTT) butterfly; sampled with the beat
- x0, x1, x2, x3  input  N each  input coefficients, caller guarantees < Q
- tf1, tf2, tf3  input  N each  twiddles for x1, x2, x3 (< Q); caller supplies inverse twiddles in INTT mode
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output
- y0, y1, y2, y3  output  N each  butterfly results, canonical in [0, Q)
- out_inv  output  1  inv flag travelling with the beat

Behaviour:
- Arithmetic, per beat, all values mod Q:
  - p1 = tf1*x1, p2 = tf2*x2, p3 = tf3*x3.
  - t0 = x0+p2, t1 = x0-p2, t2 = p1+p3.
  - t3 = (p1-p3)*R, where R = W4 if inv=0 and R = Q-W4 if inv=1.
  - y0 = t0+t2, y1 = t1+t3, y2 = t0-t2, y3 = t1-t3.
- Every intermediate value is reduced to [0, Q): subtraction adds Q when negative; products use full 2N-bit width before reduction. Reduction structure is free; results must be canonical.
- Inputs >= Q give undefined outputs; the bench does not drive them.
- Pipeline has 3 register stages:
  - S1: capture operands, compute p1, p2, p3.
  - S2: reduced products, t0..t2 and the pre-R difference.
  - S3: t3 and final y0..y3.
- Each stage holds a valid bit; the inv bit travels with the beat.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+3 when no stall occurs.
- Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted on an edge where in_valid && in_ready.
  - A beat is delivered on an edge where out_valid && out_ready.
  - Stage i advances when stage i+1 is empty or advancing; S3 advances when empty or out_ready=1.
  - in_ready = !S1_valid || S1 advancing (combinational from out_ready through the chain).
  - With out_ready=0 and all stages full, in_ready=0 and y*/out_valid/out_inv hold stable until accepted.
  - Simultaneous accept and deliver in the same cycle with a full pipe: no bubble, no loss.
  - in_valid dropping mid-stream inserts bubbles only; order is preserved.
- Reset (async assert, sync release): all stage valid bits clear, out_valid=0, y0..y3=0, out_inv=0, in_ready=1 once rst_n=1. Beats in flight when reset asserts are discarded, never emitted.

Optional Feature:
- Macro RADIX4_NTT_PE_SCALE_EN.
- Defined: for beats with inv=1, S3 additionally multiplies each y by 4^-1 mod Q, computed as two successive modular halvings (odd: add Q, then shift right 1). This adds one pipeline stage, so latency becomes 4 for all beats. inv=0 beats pass through unscaled.
- Undefined: no scaling, latency 3.

Test Plan:
- Impulse, forward: x=(1,0,0,0), tf=(1,1,1), inv=0 -> y=(1,1,1,1) with out_valid 3 cycles after accept.
- Forward vs inverse: x=(0,1,0,0), tf=(1,1,1):
  - inv=0 -> y=(1,4,16,13).
  - inv=1 -> y=(1,13,16,4), out_inv=1.
  - With RADIX4_NTT_PE_SCALE_EN, inv=1 -> y=(13,16,4,1) at latency 4.
- Wrap/modular: x=(16,16,16,16), tf=(1,1,1), inv=0 -> y=(13,0,0,0).
- Back-pressure:
  - Stream 10 random beats with out_ready=0 for cycles 4-9 -> in_ready drops after the pipe fills.
  - Outputs hold stable while stalled.
  - All 10 results emerge in order and match the golden model, none dropped or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 and y=0 immediately; after release, no stale beat appears and the next beat has latency 3.
